// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among 4 byte requesters; grant appears 1 cycle after sampling.
// No queuing: a requester holds valid until acked, and new grants wait for a full frame slot.
module uart_tx_arbiter #(
    parameter int BAUD_CNT   = 868,
    parameter int FRAME_BITS = 11,
    parameter int GAP_CYCLES = 0
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [3:0]  req_valid,
    input  logic [31:0] req_data,
    input  logic [3:0]  req_mask,
    output logic [3:0]  req_ack,
    output logic [7:0]  td_data,
    output logic        ready_flag,
    output logic [1:0]  grant_id,
    output logic        busy
);

    localparam int SLOT  = BAUD_CNT * FRAME_BITS + GAP_CYCLES;
    localparam int CNT_W = $clog2(SLOT + 1);
    // WAIT spans SLOT-1 cycles so the IDLE sample lands one cycle before the next permitted start.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SLOT - 2);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [7:0]       td_q, td_d;
    logic             rdy_q, rdy_d;
    logic [3:0]       ack_q, ack_d;
    logic [1:0]       gid_q, gid_d;
    logic             busy_q, busy_d;

    logic [3:0] elig;
    logic       win_vld;
    logic [1:0] win_idx;
    logic [1:0] cand;

    assign elig = req_valid & req_mask;

    always_comb begin
        win_vld = 1'b0;
        win_idx = ptr_q;
        cand    = ptr_q;
        for (int k = 1; k <= 4; k++) begin
            cand = ptr_q + 2'(k);
            if (!win_vld && elig[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        td_d    = td_q;
        rdy_d   = 1'b0;
        ack_d   = 4'b0000;
        gid_d   = gid_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                    ptr_d   = win_idx;
                    td_d    = req_data[{win_idx, 3'b000} +: 8];
                    rdy_d   = 1'b1;
                    ack_d   = 4'b0001 << win_idx;
                    gid_d   = win_idx;
                    busy_d  = 1'b1;
                end
            end
            WAIT: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= 2'd3;
            td_q    <= 8'h00;
            rdy_q   <= 1'b0;
            ack_q   <= 4'b0000;
            gid_q   <= 2'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            td_q    <= td_d;
            rdy_q   <= rdy_d;
            ack_q   <= ack_d;
            gid_q   <= gid_d;
            busy_q  <= busy_d;
        end
    end

    assign req_ack    = ack_q;
    assign td_data    = td_q;
    assign ready_flag = rdy_q;
    assign grant_id   = gid_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus random requesters against a slot/round-robin model.
module tb_uart_tx_arbiter;

    localparam int BAUD = 4;
    localparam int FRAME = 11;
    localparam int GAP = 2;
    localparam int SLOT = BAUD * FRAME + GAP;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [3:0]  req_valid = 4'b0;
    logic [31:0] req_data = 32'b0;
    logic [3:0]  req_mask = 4'b0;
    logic [3:0]  req_ack;
    logic [7:0]  td_data;
    logic        ready_flag;
    logic [1:0]  grant_id;
    logic        busy;

    uart_tx_arbiter #(.BAUD_CNT(BAUD), .FRAME_BITS(FRAME), .GAP_CYCLES(GAP)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .req_valid(req_valid), .req_data(req_data),
        .req_mask(req_mask), .req_ack(req_ack), .td_data(td_data), .ready_flag(ready_flag),
        .grant_id(grant_id), .busy(busy)
    );

    always #5 sys_clk = ~sys_clk;

    int pass_cnt = 0;
    int chk_cnt = 0;
    int cyc = 0;

    // Reference model: pointer, earliest cycle the arbiter may sample again, expected outputs.
    int         m_ptr = 3;
    int         m_idle_from = 0;
    logic [7:0] e_td = 0;
    logic       e_rdy = 0;
    logic [3:0] e_ack = 0;
    logic [1:0] e_gid = 0;
    logic       e_busy = 0;

    int         rdy_cyc[$];
    int         gnt_q[$];
    logic [3:0] ack_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic tick();
        logic [3:0] elig;
        int w;
        if (sys_rst) begin
            e_td = 0; e_rdy = 0; e_ack = 0; e_gid = 0; e_busy = 0;
            m_ptr = 3; m_idle_from = 0;
        end else begin
            elig = req_valid & req_mask;
            e_rdy = 0;
            e_ack = 0;
            if (cyc >= m_idle_from && elig != 0) begin
                w = -1;
                for (int k = 1; k <= 4; k++)
                    if (w < 0 && elig[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
                e_rdy = 1;
                e_ack = 4'(1 << w);
                e_td = req_data[8*w +: 8];
                e_gid = 2'(w);
                m_ptr = w;
                m_idle_from = cyc + SLOT;
                e_busy = 1;
            end else begin
                e_busy = (cyc + 1 < m_idle_from);
            end
        end
        @(posedge sys_clk);
        #1;
        cyc++;
        chk("td_data", 32'(td_data), 32'(e_td));
        chk("ready_flag", 32'(ready_flag), 32'(e_rdy));
        chk("req_ack", 32'(req_ack), 32'(e_ack));
        chk("grant_id", 32'(grant_id), 32'(e_gid));
        chk("busy", 32'(busy), 32'(e_busy));
        ack_seen |= req_ack;
        if (ready_flag) begin
            rdy_cyc.push_back(cyc);
            gnt_q.push_back(int'(grant_id));
        end
    endtask

    // Leaves sys_rst high; caller drops it for cycle 0.
    task automatic do_reset();
        sys_rst = 1;
        req_valid = 0;
        req_mask = 0;
        tick();
        tick();
        rdy_cyc.delete();
        gnt_q.delete();
        ack_seen = 0;
        cyc = 0;
    endtask

    task automatic check_grants(input string tag, input int exp_ids[5], input int n);
        chk({tag, "_count"}, 32'(gnt_q.size()), 32'(n));
        for (int i = 0; i < n && i < gnt_q.size(); i++)
            chk({tag, "_id"}, 32'(gnt_q[i]), 32'(exp_ids[i]));
        for (int i = 1; i < n && i < rdy_cyc.size(); i++)
            chk({tag, "_spacing"}, 32'(rdy_cyc[i] - rdy_cyc[i-1]), 32'(SLOT));
    endtask

    initial begin
        logic [31:0] b;
        // Reset state
        do_reset();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_td", 32'(td_data), 0);

        // Single request
        req_data = 32'h0000_0055; req_valid = 4'b0001; req_mask = 4'b1111; sys_rst = 0;
        tick();
        chk("single_rdy_c1", 32'(ready_flag), 1);
        chk("single_ack_c1", 32'(req_ack), 32'h1);
        chk("single_td_c1", 32'(td_data), 32'h55);
        req_valid = 0;
        while (cyc < SLOT - 1) tick();
        chk("single_busy_last", 32'(busy), 1);
        tick();
        chk("single_busy_fall", 32'(busy), 0);
        chk("single_td_hold", 32'(td_data), 32'h55);

        // All four always valid
        do_reset();
        req_data = 32'hA3A2_A1A0; req_valid = 4'b1111; req_mask = 4'b1111; sys_rst = 0;
        while (cyc < 4 * SLOT + 2) tick();
        check_grants("rr4", '{0, 1, 2, 3, 0}, 5);

        // Masked requesters 0 and 2
        do_reset();
        req_valid = 4'b1111; req_mask = 4'b1010; sys_rst = 0;
        while (cyc < 3 * SLOT + 2) tick();
        check_grants("mask", '{1, 3, 1, 3, 0}, 4);
        chk("mask_never_acked", 32'(ack_seen & 4'b0101), 0);

        // Dropped requester, late arrival mid-slot
        do_reset();
        req_data = 32'h0033_2211; req_valid = 4'b0001; req_mask = 4'b1111; sys_rst = 0;
        tick();
        req_valid = 4'b0000;
        while (cyc < 10) tick();
        req_valid = 4'b0010;
        while (cyc < 20) tick();
        req_valid = 4'b0000;
        while (cyc < 30) tick();
        req_valid = 4'b0100;
        while (cyc < SLOT + 3) tick();
        chk("late_grants", 32'(gnt_q.size()), 2);
        if (rdy_cyc.size() > 1) chk("late_cycle", 32'(rdy_cyc[1]), 32'(SLOT + 1));
        chk("late_dropped_noack", 32'(ack_seen[1]), 0);
        chk("late_td", 32'(td_data), 32'h33);

        // Reset mid-slot
        do_reset();
        req_data = 32'h0077_0000; req_valid = 4'b0100; req_mask = 4'b1111; sys_rst = 0;
        while (cyc < 20) tick();
        chk("midrst_busy_before", 32'(busy), 1);
        sys_rst = 1;
        tick();
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_td", 32'(td_data), 0);
        sys_rst = 0;
        tick();
        chk("midrst_regrant", 32'(ready_flag), 1);
        chk("midrst_gid", 32'(grant_id), 2);

        // Random requesters holding valid until acked
        req_valid = 0; req_mask = 4'b1111;
        for (int n = 0; n < 2500; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (req_valid[i] && req_ack[i]) begin
                    req_valid[i] = ($urandom_range(0, 1) == 1);
                    b = req_data; b[8*i +: 8] = 8'($urandom); req_data = b;
                end else if (!req_valid[i] && $urandom_range(0, 19) == 0) begin
                    req_valid[i] = 1;
                    b = req_data; b[8*i +: 8] = 8'($urandom); req_data = b;
                end else if (req_valid[i] && $urandom_range(0, 149) == 0) begin
                    req_valid[i] = 0;
                end
            end
            if ($urandom_range(0, 199) == 0) req_mask = 4'($urandom);
            sys_rst = (n == 1234);
            tick();
        end
        sys_rst = 0;

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
